// File: rtl/cdm_div32_16_if.sv
// -----------------------------------------------------------------------------
// cdm_div32_16_if
// Operand/result channel for the cdm_div32_16 restoring divider.
//   Input side : in_valid, in_ready, dividend[2*DW], divisor[DW]
//   Output side: out_valid, out_ready, quotient[DW], remainder[DW],
//                div_by_zero, overflow, chk_err
// Modports:
//   master - the producer of operands / consumer of results
//   slave  - the divider itself
// -----------------------------------------------------------------------------
interface cdm_div32_16_if #(
    parameter int DW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     quotient;
    logic [DW-1:0]     remainder;
    logic              div_by_zero;
    logic              overflow;
    logic              chk_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
               div_by_zero, overflow, chk_err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
               div_by_zero, overflow, chk_err
    );
endinterface

// File: rtl/cdm_div32_16.sv
// -----------------------------------------------------------------------------
// cdm_div32_16
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor gives a
// DW-bit quotient and DW-bit remainder, one quotient bit per cycle, MSB first.
// Intended to undo or check products of the DWxDW multiplier datapath.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (release is expected synchronous)
//   bus   - cdm_div32_16_if.slave: valid/ready operand input
//           (dividend, divisor) and valid/ready result output
//           (quotient, remainder, div_by_zero, overflow, chk_err)
//
// Optional build macro:
//   CDM_DIV_CHECK_EN - adds a one-cycle VERIFY state that recomputes
//                      quotient*divisor + remainder and flags chk_err on a
//                      mismatch with the dividend. Without it chk_err is 0.
//
// Latency from accept to out_valid: 1 cycle for divide-by-zero / overflow,
// DW+1 cycles for a normal divide (DW+2 with CDM_DIV_CHECK_EN).
// -----------------------------------------------------------------------------
module cdm_div32_16 #(
    parameter int DW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cdm_div32_16_if.slave  bus
);
    localparam int CW = $clog2(DW);

`ifdef CDM_DIV_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_VERIFY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t          state_reg;
    state_t          state_next;

    logic [DW-1:0]   divisor_reg;
    logic [DW-1:0]   lo_reg;      // dividend low half, shifted left each step
    logic [DW-1:0]   p_reg;       // partial remainder; always < divisor so DW bits suffice
    logic [DW-1:0]   quo_reg;
    logic [DW-1:0]   rem_reg;
    logic [CW-1:0]   cnt_reg;
    logic            dz_reg;
    logic            ov_reg;

    logic [DW-1:0]   hi_in;
    logic            is_dz;
    logic            is_ov;
    logic            accept;
    logic [DW:0]     p_shift;
    logic            ge;
    logic [DW-1:0]   p_step;
    logic            last_step;

    assign hi_in     = bus.dividend[2*DW-1:DW];
    assign is_dz     = (bus.divisor == '0);
    // A quotient that fits DW bits requires the high half to be below the divisor.
    assign is_ov     = (hi_in >= bus.divisor);
    assign accept    = (state_reg == S_IDLE) && bus.in_valid;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign p_shift   = {p_reg, lo_reg[DW-1]};
    assign ge        = (p_shift >= {1'b0, divisor_reg});
    assign p_step    = ge ? DW'(p_shift - {1'b0, divisor_reg}) : p_shift[DW-1:0];
    assign last_step = (cnt_reg == '0);

`ifdef CDM_DIV_CHECK_EN
    logic [2*DW-1:0] dividend_reg;
    logic            chk_reg;
    logic [2*DW-1:0] chk_sum;

    assign chk_sum = (2*DW)'(quo_reg) * (2*DW)'(divisor_reg) + (2*DW)'(rem_reg);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_next = (is_dz || is_ov) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
`ifdef CDM_DIV_CHECK_EN
                    state_next = S_VERIFY;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef CDM_DIV_CHECK_EN
            S_VERIFY: state_next = S_DONE;
`endif
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        bus.in_ready    = (state_reg == S_IDLE);
        bus.out_valid   = (state_reg == S_DONE);
        bus.quotient    = quo_reg;
        bus.remainder   = rem_reg;
        bus.div_by_zero = dz_reg;
        bus.overflow    = ov_reg;
`ifdef CDM_DIV_CHECK_EN
        bus.chk_err     = chk_reg;
`else
        bus.chk_err     = 1'b0;
`endif
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_reg  <= '0;
            lo_reg       <= '0;
            p_reg        <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            dz_reg       <= 1'b0;
            ov_reg       <= 1'b0;
`ifdef CDM_DIV_CHECK_EN
            dividend_reg <= '0;
            chk_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        divisor_reg <= bus.divisor;
                        lo_reg      <= bus.dividend[DW-1:0];
                        p_reg       <= hi_in;
                        cnt_reg     <= CW'(DW - 1);
                        dz_reg      <= is_dz;
                        ov_reg      <= !is_dz && is_ov;
`ifdef CDM_DIV_CHECK_EN
                        dividend_reg <= bus.dividend;
                        chk_reg      <= 1'b0;
`endif
                        // Special cases saturate the quotient and pass the low half through.
                        if (is_dz || is_ov) begin
                            quo_reg <= '1;
                            rem_reg <= bus.dividend[DW-1:0];
                        end
                    end
                end
                S_RUN: begin
                    p_reg   <= p_step;
                    quo_reg <= {quo_reg[DW-2:0], ge};
                    lo_reg  <= lo_reg << 1;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (last_step) begin
                        rem_reg <= p_step;
                    end
                end
`ifdef CDM_DIV_CHECK_EN
                S_VERIFY: begin
                    chk_reg <= (chk_sum != dividend_reg);
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cdm_div32_16.md
Name: cdm_div32_16

Overview:
- Sequential restoring divider that inverts the 16x16 multiplier path: 32-bit dividend / 16-bit divisor -> 16-bit quotient + 16-bit remainder.
- Exact arithmetic; used to undo or check products from the multiplier datapath.
- Produces one quotient bit per cycle, MSB first.
- valid/ready handshake on both input and output sides.

Parameters:
DW, 16, divisor/quotient/remainder width; dividend width is 2*DW

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
dividend  input  2*DW  numerator
divisor  input  DW  denominator
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DW  quotient
remainder  output  DW  remainder
div_by_zero  output  1  divisor was 0
overflow  output  1  quotient does not fit in DW bits
chk_err  output  1  self-check mismatch (CDM_DIV_CHECK_EN only)

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; quotient, remainder, div_by_zero, overflow, chk_err all 0.
- Reset mid-operation aborts the division; no result is emitted.
- States: IDLE, RUN, (VERIFY when enabled), DONE.
- IDLE:
  - in_ready=1.
  - An accept (in_valid&&in_ready) latches dividend and divisor.
  - If divisor==0: div_by_zero=1, quotient=all ones, remainder=dividend[DW-1:0]; go to DONE.
  - Else if dividend[2DW-1:DW] >= divisor: overflow=1, quotient=all ones, remainder=dividend[DW-1:0]; go to DONE.
  - Else: partial remainder P (DW+1 bits) = dividend high half; iteration counter = DW-1; go to RUN.
- RUN, one step per cycle:
  - P' = {P[DW-1:0], next dividend low bit (MSB first)}.
  - If P' >= divisor: P = P'-divisor, quotient bit = 1.
  - Else: P = P', quotient bit = 0.
  - After DW steps: remainder = P[DW-1:0]; go to VERIFY if enabled, else DONE.
- Latency from the accept cycle to out_valid=1:
  - Special cases: 1 cycle.
  - Normal: DW+1 cycles (DW+2 with CDM_DIV_CHECK_EN).
- DONE:
  - out_valid=1, in_ready=0.
  - All outputs held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle; flags cleared on the next accept.
- in_ready is 0 in RUN, VERIFY and DONE. The block never accepts input in the same cycle as a result handshake.
- in_valid while busy is ignored. The upstream holds operands until accepted.
- Results satisfy quotient*divisor + remainder == dividend and remainder < divisor whenever div_by_zero=0 and overflow=0.
- The two flags are mutually exclusive; div_by_zero has priority.

Optional Feature:
- Macro: CDM_DIV_CHECK_EN
- Defined:
  - VERIFY state inserted after RUN, one cycle.
  - Computes quotient*divisor + remainder with an exact 2*DW-bit multiply-add.
  - Compares the result with the latched dividend; sets chk_err=1 on mismatch.
  - Special-case results skip VERIFY with chk_err=0.
- Not defined:
  - No VERIFY state, no multiplier logic.
  - chk_err tied to 0; normal latency DW+1.

Test Plan:
- dividend=0x0001_0000, divisor=0x0003 -> quotient=0x5555, remainder=0x0001, flags 0, out_valid exactly 17 cycles after accept (18 with CDM_DIV_CHECK_EN).
- dividend=0xFFFE_0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0x0000, overflow=0, chk_err=0.
- dividend=0x1234_5678, divisor=0x0000 -> div_by_zero=1, quotient=0xFFFF, remainder=0x5678, out_valid 1 cycle after accept.
- dividend=0x0005_0000, divisor=0x0004 -> overflow=1, div_by_zero=0, quotient=0xFFFF, remainder=0x0000.
- out_ready held 0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; after out_ready pulse, in_ready=1 next cycle and next operand pair is processed correctly.
- rst_n asserted at cycle 8 of a normal division -> out_valid=0 and in_ready=1 immediately; a new division 0x0000_0064/0x0007 then yields quotient=0x000E, remainder=0x0002.
